// File: rtl/graphics_pkg.sv
// rtl/graphics_pkg.sv - shared graphics constants, requester id type and named requester indices
package graphics_pkg;

  localparam int NUM_REQ       = 5;
  localparam int SPRITE_ADDR_W = 12;
  localparam int PIXEL_W       = 12;

  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

  localparam req_id_t REQ_TILE = 3'd0;
  localparam req_id_t REQ_P1   = 3'd1;
  localparam req_id_t REQ_P2   = 3'd2;
  localparam req_id_t REQ_P3   = 3'd3;
  localparam req_id_t REQ_P4   = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts one past last and wraps
module rr_pick
  import graphics_pkg::*;
#(
  parameter int N    = NUM_REQ,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = ID_W'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// rtl/sprite_fetch_arbiter.sv - round-robin sprite ROM arbiter with latency-tracked responses and starvation flags
// Optional SPRITE_ARB_TILE_PRIORITY_EN: tile fetcher (index 0) gets strict priority.
module sprite_fetch_arbiter #(
  parameter int NUM_REQ  = graphics_pkg::NUM_REQ,
  parameter int ADDR_W   = graphics_pkg::SPRITE_ADDR_W,
  parameter int DATA_W   = graphics_pkg::PIXEL_W,
  parameter int ROM_LAT  = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       line_start,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [DATA_W-1:0]          rom_data,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [NUM_REQ-1:0]         stall_err
);
  import graphics_pkg::*;

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] WAIT_SAT  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_PRE  = CNT_W'(MAX_WAIT - 1);

  logic [ID_W-1:0]    last_q;
  logic [NUM_REQ-1:0] rr_req, rr_gnt, gnt;
  logic [ID_W-1:0]    rr_idx, gnt_idx;
  logic               rr_used, grant_any;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req     (rr_req),
    .last    (last_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

`ifdef SPRITE_ARB_TILE_PRIORITY_EN
  // The tile fetcher never enters the rotation, so last only ever names a player.
  assign rr_req = {req_valid[NUM_REQ-1:1], 1'b0};

  always_comb begin
    gnt     = rr_gnt;
    gnt_idx = rr_idx;
    rr_used = |rr_gnt;
    if (req_valid[REQ_TILE]) begin
      gnt               = '0;
      gnt[REQ_TILE]     = 1'b1;
      gnt_idx           = ID_W'(REQ_TILE);
      rr_used           = 1'b0;
    end
  end
`else
  assign rr_req  = req_valid;
  assign gnt     = rr_gnt;
  assign gnt_idx = rr_idx;
  assign rr_used = |rr_gnt;
`endif

  assign grant_any = |gnt;
  assign req_ready = reset ? gnt : '0;

  // id_vld/id_idx[s] describe the read issued s cycles after rom_en rose
  logic [ROM_LAT:0] id_vld;
  logic [ID_W-1:0]  id_idx [ROM_LAT+1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q    <= LAST_INIT;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      id_vld    <= '0;
      for (int s = 0; s <= ROM_LAT; s++) id_idx[s] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (line_start)   last_q <= LAST_INIT;
      else if (rr_used) last_q <= rr_idx;
      rom_en <= grant_any;
      if (grant_any) rom_addr <= addr_arr[gnt_idx];
      id_vld    <= {id_vld[ROM_LAT-1:0], grant_any};
      id_idx[0] <= gnt_idx;
      for (int s = 1; s <= ROM_LAT; s++) id_idx[s] <= id_idx[s-1];
      rsp_valid <= id_vld[ROM_LAT] ? (NUM_REQ'(1) << id_idx[ROM_LAT]) : '0;
      if (id_vld[ROM_LAT]) rsp_data <= rom_data;
    end
  end

  logic [CNT_W-1:0] wait_cnt [NUM_REQ];

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!reset) begin
        wait_cnt[i]  <= '0;
        stall_err[i] <= 1'b0;
      end else begin
        if (req_valid[i] && !gnt[i]) begin
          if (wait_cnt[i] != WAIT_SAT) wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
        // Raised on the edge where the counter lands on MAX_WAIT; beats a same-cycle clear.
        if (req_valid[i] && !gnt[i] && wait_cnt[i] >= WAIT_PRE) stall_err[i] <= 1'b1;
        else if (line_start)                                   stall_err[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// tb/tb_sprite_fetch_arbiter.sv - directed and random bench for sprite_fetch_arbiter against a queue-based reference model
module tb_sprite_fetch_arbiter;
  localparam int N    = 5;
  localparam int AW   = 12;
  localparam int DW   = 12;
  localparam int LAT  = 2;
  localparam int MAXW = 15;
`ifdef SPRITE_ARB_TILE_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          line_start;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ready;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] rom_pipe = '0;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [N-1:0]  stall_err;
  logic [AW-1:0] addr_a [N];

  always_comb begin
    req_addr = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_a[i];
  end

  // ROM: word = address ^ 0xAAC, two cycles after rom_en is sampled
  always @(posedge clk) begin
    rom_pipe <= rom_addr ^ 12'hAAC;
    rom_data <= rom_pipe;
  end

  sprite_fetch_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT), .MAX_WAIT(MAXW)) dut (
    .clock(clk), .reset(rst_n), .line_start(line_start),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .stall_err(stall_err)
  );

  typedef struct {int due; int idx; logic [DW-1:0] data;} rsp_t;
  rsp_t          rsp_q[$];
  int            n_chk = 0, n_fail = 0, cyc = 0;
  int            m_last = N - 1;
  int            m_run [N];
  bit            m_stall [N];
  logic          m_rom_en = 1'b0;
  logic [AW-1:0] m_rom_addr = '0;
  logic [DW-1:0] m_rsp_data = '0;
  int            last_g = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    if (PRIO && v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx] && !(PRIO && idx == 0)) return idx;
    end
    return -1;
  endfunction

  task automatic check_cycle();
    int g;
    logic [N-1:0] exp_ready, exp_rsp, exp_stall;
    g = rst_n ? pick(req_valid, m_last) : -1;
    exp_ready = (g >= 0) ? N'(1) << g : '0;
    exp_rsp = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      exp_rsp = N'(1) << rsp_q[0].idx;
      m_rsp_data = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    exp_stall = '0;
    for (int i = 0; i < N; i++) exp_stall[i] = m_stall[i];
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rom_en", 32'(rom_en), 32'(m_rom_en));
    chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
    chk("stall_err", 32'(stall_err), 32'(exp_stall));
    last_g = g;
    if (!rst_n) begin
      m_last = N - 1;
      rsp_q.delete();
      m_rom_en = 1'b0;
      m_rom_addr = '0;
      m_rsp_data = '0;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_stall[i] = 1'b0; end
    end else begin
      m_rom_en = (g >= 0);
      if (g >= 0) begin
        m_rom_addr = addr_a[g];
        rsp_q.push_back('{cyc + LAT + 2, g, addr_a[g] ^ 12'hAAC});
      end
      for (int i = 0; i < N; i++) begin
        m_run[i] = (req_valid[i] && g != i) ? m_run[i] + 1 : 0;
        if (m_run[i] >= MAXW) m_stall[i] = 1'b1;
        else if (line_start) m_stall[i] = 1'b0;
      end
      if (line_start) m_last = N - 1;
      else if (g >= 0 && !(PRIO && g == 0)) m_last = g;
    end
  endtask

  task automatic step();
    #3;
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    line_start = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    line_start = 1'b0;
    req_valid = '1;
    for (int i = 0; i < N; i++) begin addr_a[i] = '0; m_run[i] = 0; m_stall[i] = 1'b0; end
    @(posedge clk);
    #1;
    step();
    step();
    rst_n = 1'b1;
    idle(3);

    // single request from player 2
    req_valid = 5'b00100;
    addr_a[2] = 12'h010;
    step();
    idle(6);

    // all five held valid for ten cycles
    for (int i = 0; i < N; i++) addr_a[i] = 12'(12'h100 + i);
    req_valid = '1;
    for (int i = 0; i < 10; i++) step();
    idle(6);

    // grant to 2, line_start pulse, then 1 and 3 compete
    req_valid = 5'b00100;
    addr_a[2] = 12'h222;
    step();
    req_valid = '0;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    req_valid = 5'b01010;
    addr_a[1] = 12'h111;
    addr_a[3] = 12'h333;
    step();
    step();
    idle(6);

    // reset lands one cycle after grants to 0 and 1
    req_valid = 5'b00011;
    addr_a[0] = 12'h0A0;
    addr_a[1] = 12'h0B1;
    step();
    step();
    req_valid = '0;
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    idle(6);
    req_valid = 5'b10000;
    addr_a[4] = 12'h444;
    step();
    idle(6);

    // tile and player 3 held high, line_start after the starvation window
    req_valid = 5'b01001;
    addr_a[0] = 12'h0C0;
    addr_a[3] = 12'h3C3;
    for (int i = 0; i < 20; i++) step();
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    req_valid = '0;
    line_start = 1'b1;
    step();
    idle(6);

    // random traffic; pending requests keep their valid and address
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_g != i)) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          addr_a[i] = 12'($urandom_range(0, 4095));
        end
      end
      line_start = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    idle(8);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
